// File: rtl/id_stage_pkg.sv
// Shared decode constants for the decode stage: opcodes, functs, ExcCodes, forward selects,
// and the legal-instruction check used for reserved-instruction detection.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f, OP_COP0  = 6'h10, OP_LB    = 6'h20, OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23, OP_LBU   = 6'h24, OP_LHU   = 6'h25, OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;

  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_RI = 5'd10;

  localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2
  } fwd_sel_e;

  function automatic logic is_legal(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    case (ins[31:26])
      OP_RTYPE: begin
        case (ins[5:0])
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0c,
          6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: ok = 1'b1;
          default:      ok = 1'b0;
        endcase
      end
      // mfc0 (rs=0), mtc0 (rs=4) and eret are the only coprocessor-0 forms accepted
      OP_COP0: ok = (ins[25:21] == 5'd0) || (ins[25:21] == 5'd4) || (ins == INSTR_ERET);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_grf.sv
// 32x32 general register file: two async read ports with write-first bypass, one sync write port.
// Optional write trace enabled by defining GRF_DISPLAY_EN.
module id_stage_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] wpc_i
);

  // $0 has no storage; the read muxes return zero for it
  logic [31:0] regs_q [1:31];

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset)
          regs_q[gi] <= '0;
        else if (we_i && (wa_i == 5'(gi)))
          regs_q[gi] <= wd_i;
      end
    end
  endgenerate

  always_comb begin
    rd1_o = '0;
    if (ra1_i != 5'd0)
      rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i != 5'd0)
      rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
  end

`ifdef GRF_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset && we_i && (wa_i != 5'd0))
      $display("@%h: $%d <= %h", wpc_i, wa_i, wd_i);
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^wpc_i;
`endif

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: GRF read, forwarding, next-PC/branch resolution, RI detection, DE register.
// GRF_DISPLAY_EN enables the register-write trace inside the register file.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FD_instruc,
  input  logic [31:0] FD_PC,
  input  logic [4:0]  FD_Exc,
  input  logic        FD_BD,
  input  logic [31:0] F_PC,
  input  logic [31:0] EPC,
  input  logic        stall,
  input  logic        IntReq,
  input  logic [1:0]  fwd_rs_sel,
  input  logic [1:0]  fwd_rt_sel,
  input  logic [31:0] E_fwd_data,
  input  logic [31:0] M_fwd_data,
  input  logic        W_we,
  input  logic [4:0]  W_addr,
  input  logic [31:0] W_wdata,
  input  logic [31:0] W_PC,
  output logic [31:0] D_NPC,
  output logic        eJump,
  output logic [4:0]  D_rs_addr,
  output logic [4:0]  D_rt_addr,
  output logic [31:0] DE_instruc,
  output logic [31:0] DE_PC,
  output logic [31:0] DE_rs_val,
  output logic [31:0] DE_rt_val,
  output logic [31:0] DE_imm_ext,
  output logic [4:0]  DE_Exc,
  output logic        DE_BD
);

  logic [31:0] unused_pc_lo;
  assign unused_pc_lo = PC_LO;

  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [31:0] grf_rs, grf_rt, rs_val, rt_val, imm_ext, branch_off;
  logic [4:0]  exc_d;
  logic        is_eret, is_jr, is_j;

  assign op        = FD_instruc[31:26];
  assign funct     = FD_instruc[5:0];
  assign imm       = FD_instruc[15:0];
  assign D_rs_addr = FD_instruc[25:21];
  assign D_rt_addr = FD_instruc[20:16];

  id_stage_grf u_grf (
    .clk   (clk),
    .reset (reset),
    .ra1_i (D_rs_addr),
    .ra2_i (D_rt_addr),
    .rd1_o (grf_rs),
    .rd2_o (grf_rt),
    .we_i  (W_we),
    .wa_i  (W_addr),
    .wd_i  (W_wdata),
    .wpc_i (W_PC)
  );

  always_comb begin
    case (fwd_rs_sel)
      FWD_E:   rs_val = E_fwd_data;
      FWD_M:   rs_val = M_fwd_data;
      default: rs_val = grf_rs;
    endcase
    case (fwd_rt_sel)
      FWD_E:   rt_val = E_fwd_data;
      FWD_M:   rt_val = M_fwd_data;
      default: rt_val = grf_rt;
    endcase
  end

  assign is_eret    = (FD_instruc == INSTR_ERET);
  assign is_jr      = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
  assign is_j       = (op == OP_J) || (op == OP_JAL);
  assign branch_off = {{14{imm[15]}}, imm, 2'b00};
  assign eJump      = is_eret;

  always_comb begin
    D_NPC = F_PC + 32'd4;
    if (reset)
      D_NPC = RESET_PC;
    else if (is_eret)
      D_NPC = EPC;
    else if (is_j)
      D_NPC = {FD_PC[31:28], FD_instruc[25:0], 2'b00};
    else if (is_jr)
      D_NPC = rs_val;
    else if (((op == OP_BEQ) && (rs_val == rt_val)) || ((op == OP_BNE) && (rs_val != rt_val)))
      D_NPC = FD_PC + 32'd4 + branch_off;
  end

  // logical immediates are zero-extended, everything else sign-extended
  assign imm_ext = ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI)) ?
                   {16'h0000, imm} : {{16{imm[15]}}, imm};

  always_comb begin
    exc_d = EXC_INT;
    if (FD_Exc != 5'd0)
      exc_d = FD_Exc;
    else if (!is_legal(FD_instruc))
      exc_d = EXC_RI;
  end

  logic [31:0] instr_q, pc_q, rs_q, rt_q, imm_q;
  logic [4:0]  exc_q;
  logic        bd_q;

  always_ff @(posedge clk) begin
    if (reset || IntReq) begin
      instr_q <= '0; pc_q <= '0; rs_q <= '0; rt_q <= '0;
      imm_q   <= '0; exc_q <= '0; bd_q <= 1'b0;
    end else if (stall) begin
      // bubble keeps PC/BD so CP0 reports the right EPC if it is interrupted
      instr_q <= '0; rs_q <= '0; rt_q <= '0; imm_q <= '0; exc_q <= '0;
      pc_q    <= FD_PC;
      bd_q    <= FD_BD;
    end else begin
      instr_q <= FD_instruc; pc_q <= FD_PC; rs_q <= rs_val; rt_q <= rt_val;
      imm_q   <= imm_ext;    exc_q <= exc_d; bd_q <= FD_BD;
    end
  end

  assign DE_instruc = instr_q;
  assign DE_PC      = pc_q;
  assign DE_rs_val  = rs_q;
  assign DE_rt_val  = rt_q;
  assign DE_imm_ext = imm_q;
  assign DE_Exc     = exc_q;
  assign DE_BD      = bd_q;

endmodule
